// File: rtl/divisor_base_finder.sv
// Sequential power-of-ten base finder for the Nikhilam divider: walks 10^k one step
// per cycle, then reports base, exponent, signed complement and a near-base flag.
module divisor_base_finder #(
    parameter int WIDTH    = 16,
    parameter int NEAR_NUM = 3,
    parameter int NEAR_DEN = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   abort,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_divisor,
    input  logic                   in_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH+3:0]       out_base,
    output logic [2:0]             out_exp,
    output logic signed [WIDTH+4:0] out_diff,
    output logic                   out_near,
    output logic                   out_zero
);

    // Smallest k with 10^k > 2^w - 1: the last exponent the search may ever need.
    function automatic int calc_max_exp(input int w);
        longint unsigned lim;
        longint unsigned p;
        int              k;
        lim = (64'd1 << w) - 64'd1;
        p   = 64'd10;
        k   = 1;
        while (p <= lim) begin
            p = p * 64'd10;
            k = k + 1;
        end
        return k;
    endfunction

    localparam int BASE_W  = WIDTH + 4;
    localparam int MAX_EXP = calc_max_exp(WIDTH);
    localparam int NW      = BASE_W + 8;

    localparam logic [NW-1:0]     NEAR_NUM_W = NW'(NEAR_NUM);
    localparam logic [NW-1:0]     NEAR_DEN_W = NW'(NEAR_DEN);
    localparam logic [BASE_W-1:0] BASE_TEN   = BASE_W'(10);
    localparam logic [2:0]        EXP_LAST   = 3'(MAX_EXP);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                  state_q;
    logic [WIDTH-1:0]        d_q;
    logic                    mode_q;
    logic [BASE_W-1:0]       p_q;
    logic [2:0]              k_q;

    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [BASE_W-1:0]       out_base_q;
    logic [2:0]              out_exp_q;
    logic signed [BASE_W:0]  out_diff_q;
    logic                    out_near_q;
    logic                    out_zero_q;

    logic [BASE_W-1:0]       d_ext;
    logic [BASE_W:0]         p_x2;
    logic [BASE_W-1:0]       p_d;
    logic [2:0]              k_d;
    logic                    hit_d;
    logic signed [BASE_W:0]  diff_d;
    logic [BASE_W-1:0]       abs_d;
    logic [NW-1:0]           near_lhs_d;
    logic [NW-1:0]           near_rhs_d;
    logic                    near_d;

    assign d_ext = {{(BASE_W-WIDTH){1'b0}}, d_q};
    assign p_x2  = {p_q, 1'b0};
    // x10 as shift-add; cannot overflow because the search stops at MAX_EXP.
    assign p_d   = (p_q << 3) + (p_q << 1);
    assign k_d   = k_q + 3'd1;

    always_comb begin
        hit_d = 1'b0;
        if (mode_q)
            hit_d = (p_q >= d_ext);
        else
            hit_d = ({1'b0, d_ext} < p_x2);
        if (k_q == EXP_LAST)
            hit_d = 1'b1;
    end

    assign diff_d = $signed({1'b0, p_q}) - $signed({1'b0, d_ext});
    assign abs_d  = (p_q >= d_ext) ? (p_q - d_ext) : (d_ext - p_q);

    // Strict tolerance test, widened so neither product can wrap.
    assign near_lhs_d = {8'd0, abs_d} * NEAR_DEN_W;
    assign near_rhs_d = {8'd0, p_q} * NEAR_NUM_W;
    assign near_d     = (near_lhs_d < near_rhs_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            d_q         <= '0;
            mode_q      <= 1'b0;
            p_q         <= BASE_TEN;
            k_q         <= 3'd1;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_base_q  <= BASE_TEN;
            out_exp_q   <= 3'd1;
            out_diff_q  <= '0;
            out_near_q  <= 1'b0;
            out_zero_q  <= 1'b0;
        end else if (abort) begin
            // Result registers keep their contents; only the handshake is dropped.
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        d_q        <= in_divisor;
                        mode_q     <= in_mode;
                        p_q        <= BASE_TEN;
                        k_q        <= 3'd1;
                        in_ready_q <= 1'b0;
                        state_q    <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (hit_d) begin
                        state_q <= CHECK;
                    end else begin
                        p_q <= p_d;
                        k_q <= k_d;
                    end
                end
                CHECK: begin
                    out_base_q  <= p_q;
                    out_exp_q   <= k_q;
                    out_diff_q  <= diff_d;
                    out_near_q  <= near_d;
                    out_zero_q  <= (d_q == '0);
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_base  = out_base_q;
    assign out_exp   = out_exp_q;
    assign out_diff  = out_diff_q;
    assign out_near  = out_near_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_divisor_base_finder.sv
// Scoreboard bench for divisor_base_finder: directed and random requests checked
// against an arithmetic reference model, plus reset/abort/back-pressure scenarios.
module tb_divisor_base_finder;

    localparam int WIDTH    = 16;
    localparam int NEAR_NUM = 3;
    localparam int NEAR_DEN = 10;
    localparam int MAX_EXP  = 5;

    logic                    clk;
    logic                    rst;
    logic                    abort;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        in_divisor;
    logic                    in_mode;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH+3:0]        out_base;
    logic [2:0]              out_exp;
    logic signed [WIDTH+4:0] out_diff;
    logic                    out_near;
    logic                    out_zero;

    divisor_base_finder #(
        .WIDTH    (WIDTH),
        .NEAR_NUM (NEAR_NUM),
        .NEAR_DEN (NEAR_DEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_divisor (in_divisor),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_base   (out_base),
        .out_exp    (out_exp),
        .out_diff   (out_diff),
        .out_near   (out_near),
        .out_zero   (out_zero)
    );

    typedef struct {
        longint base;
        longint expk;
        longint diff;
        longint near;
        longint zero;
        longint acc;
        int     d;
        int     m;
    } exp_t;

    exp_t   sb_q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    bit     hold_ready = 0;

    bit     active = 0;
    bit     hs_seen = 0;
    longint snap_base, snap_exp, snap_diff, snap_near, snap_zero;

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: smallest power of ten satisfying the mode rule, capped at MAX_EXP.
    function automatic exp_t model(input int d, input int m);
        exp_t   e;
        longint p;
        longint ad;
        int     k;
        p = 1;
        for (k = 1; k <= MAX_EXP; k++) begin
            p = p * 10;
            if (k == MAX_EXP) break;
            if (m == 1 && p >= d) break;
            if (m == 0 && d < 2 * p) break;
        end
        e.base = p;
        e.expk = k;
        e.diff = p - d;
        ad     = (e.diff < 0) ? -e.diff : e.diff;
        e.near = (ad * NEAR_DEN < p * NEAR_NUM) ? 1 : 0;
        e.zero = (d == 0) ? 1 : 0;
        e.acc  = 0;
        e.d    = d;
        e.m    = m;
        return e;
    endfunction

    task automatic send(input int d, input int m, input bit expect_result);
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        in_valid   = 1'b1;
        in_divisor = d[WIDTH-1:0];
        in_mode    = m[0];
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready && !abort) break;
            n++;
            if (n > 200) break;
        end
        chk("accept_timeout", (n > 200) ? 1 : 0, 0);
        if (expect_result && n <= 200) begin
            e = model(d, m);
            e.acc = cyc + 1;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_divisor = WIDTH'($urandom);
        in_mode    = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", (n >= 2000) ? 1 : 0, 0);
    endtask

    task automatic monitor_step();
        exp_t e;
        if (rst) begin
            active  = 0;
            hs_seen = 0;
        end else if (out_valid) begin
            chk("in_ready_while_valid", in_ready, 0);
            if (!active) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    $display("result d=%0d mode=%0d base=%0d exp=%0d diff=%0d near=%0d zero=%0d lat=%0d",
                             e.d, e.m, out_base, out_exp, out_diff, out_near, out_zero, cyc - e.acc);
                    chk("base", out_base, e.base);
                    chk("exp", out_exp, e.expk);
                    chk("diff", out_diff, e.diff);
                    chk("near", out_near, e.near);
                    chk("zero", out_zero, e.zero);
                    chk("latency", cyc - e.acc, e.expk + 1);
                end
                active    = 1;
                snap_base = out_base;
                snap_exp  = out_exp;
                snap_diff = out_diff;
                snap_near = out_near;
                snap_zero = out_zero;
            end else begin
                chk("hold_stable",
                    (out_base == snap_base && out_exp == snap_exp && out_diff == snap_diff &&
                     out_near == snap_near && out_zero == snap_zero) ? 1 : 0, 1);
            end
            if (out_ready) begin
                active  = 0;
                hs_seen = 1;
            end
        end else if (hs_seen) begin
            chk("in_ready_after_handshake", in_ready, 1);
            hs_seen = 0;
        end
    endtask

    task automatic run_stim();
        int dirs_d[9] = '{9, 7, 13, 150, 150, 1000, 65535, 0, 0};
        int dirs_m[9] = '{0, 0, 0, 0, 1, 1, 0, 0, 1};
        int n;
        int d;
        int pw;

        foreach (dirs_d[i]) send(dirs_d[i], dirs_m[i], 1'b1);
        wait_idle();

        // Back-pressure: result must stay put while out_ready is held low.
        hold_ready = 1;
        send(95, 0, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("hold_valid_timeout", (n >= 50) ? 1 : 0, 0);
        repeat (4) @(negedge clk);
        hold_ready = 0;
        send(200, 1, 1'b1);
        wait_idle();

        // Asynchronous reset in the middle of a search.
        send(50000, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_base", out_base, 10);
        chk("rst_out_exp", out_exp, 1);
        chk("rst_out_diff", out_diff, 0);
        chk("rst_out_near", out_near, 0);
        chk("rst_out_zero", out_zero, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Abort mid-search: back to IDLE next cycle, nothing emitted.
        send(50000, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", in_ready, 1);
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("abort_no_output", n, 0);

        // Abort together with in_valid in IDLE blocks the accept.
        @(posedge clk);
        #1;
        abort      = 1'b1;
        in_valid   = 1'b1;
        in_divisor = 16'd123;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        abort    = 1'b0;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid || !in_ready) n++;
        end
        chk("abort_blocks_accept", n, 0);

        send(11, 0, 1'b1);
        wait_idle();

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 2))
                0: d = $urandom_range(0, 65535);
                1: d = $urandom_range(0, 250);
                default: begin
                    pw = 10;
                    repeat ($urandom_range(0, 3)) pw = pw * 10;
                    d = pw + $urandom_range(0, 8) - 4;
                    if (d > 65535) d = 65535;
                end
            endcase
            send(d, $urandom_range(0, 1), 1'b1);
        end
        wait_idle();
    endtask

    initial begin
        rst        = 1'b1;
        abort      = 1'b0;
        in_valid   = 1'b0;
        in_divisor = '0;
        in_mode    = 1'b0;
        out_ready  = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_base", out_base, 10);
        chk("reset_out_exp", out_exp, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
            run_stim();
            begin
                repeat (40000) @(posedge clk);
                chk("watchdog_expired", 1, 0);
            end
        join_any

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
